fp32_mul_round_norm: RTL and testbench
======================================

Name: fp32_mul_round_norm

Overview:
- Back-end stage of the FP32 multiplier.
- Consumes the raw 48-bit significand product, the sign and the biased exponent sum from the multiplier datapath. Produces an IEEE-754 binary32 result, rounded to nearest-even, plus status flags.
- 2-stage pipeline with a valid/ready handshake on both sides, so multiplier issue can stall on downstream backpressure.

Parameters:
- XLEN, 32, result width; only 32 is supported.
- EXP_W, 8, exponent field width.
- MAN_W, 23, fraction field width.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream product valid.
- in_ready  output  1  stage can accept the product this cycle.
- in_sign  input  1  sign (signA XOR signB).
- in_exp  input  10  signed two's complement eA+eB-127.
- in_mant  input  48  significand product; binary point between bits 46 and 45; value in [1,4).
- in_zero  input  1  special case: product is zero.
- in_inf  input  1  special case: product is infinity.
- in_nan  input  1  special case: product is NaN (includes inf*0).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- result  output  32  binary32 result.
- overflow  output  1  exponent overflow.
- underflow  output  1  tiny result.
- inexact  output  1  rounding discarded nonzero bits.

Behaviour:
- Reset: v1, v2, out_valid, result, all flags = 0. in_ready = 1 on the first cycle after reset. Reset mid-operation discards all in-flight data.
- Handshake:
  - Transfer on in_valid & in_ready, and on out_valid & out_ready.
  - adv2 = !v2 | out_ready.
  - adv1 = !v1 | adv2.
  - in_ready = adv1 (combinational, no loop through in_valid).
  - While out_valid & !out_ready, result and flags are held stable.
- Latency: 2 cycles from input acceptance to out_valid with no stall. Full throughput, 1 per cycle.
- Stage 1 (normalize):
  - If in_mant[47]=1: frac = mant[46:24], guard = mant[23], sticky = OR(mant[22:0]), e = in_exp+1.
  - Else: frac = mant[45:23], guard = mant[22], sticky = OR(mant[21:0]), e = in_exp.
  - Special flags are pipelined alongside.
- Stage 2 (round/pack):
  - Round up when guard & (sticky | frac[0]).
  - A carry out of frac sets frac=0 and increments e.
  - inexact = guard | sticky.
  - e >= 255: result = {sign, 8'hFF, 0}, overflow=1, inexact=1.
  - e <= 0: underflow path, see Optional Feature.
  - Otherwise: result = {sign, e[7:0], frac}.
- Special-case priority: nan > inf > zero > normal.
  - nan: result = 0x7FC00000.
  - inf: result = {sign, 0x7F800000}.
  - zero: result = {sign, 31'b0}.
  - All flags = 0 for special cases.
- Simultaneous output accept and input accept in the same cycle: both take effect; no bubble is inserted.

Optional Feature:
- Macro: FPMUL_SUBNORMAL_EN.
- Defined:
  - When e <= 0, the stage-2 input is denormalized before rounding.
  - Shift amount = 1-e, saturated at 26.
  - The hidden 1 is included in the shift; the shifted-out bits fold into guard/sticky, then RNE is applied.
  - Result = {sign, 8'h00, frac}; a round carry into bit 23 yields exponent field 1.
  - underflow = 1 only if the result is tiny and inexact.
- Undefined:
  - e <= 0 flushes to {sign, 31'b0}.
  - underflow=1, inexact=1.

Test Plan:
- Normal pass-through: exp=127, mant=48'h400000_000000 -> result 0x3F800000, all flags 0, out_valid exactly 2 cycles after accept.
- Normalize shift: exp=127, mant=48'hC00000_000000 -> 0x40400000 (3.0). Exp=127, mant=48'h7FFFFF_FFFFFF -> 0x40000000 (round carry), inexact=1.
- RNE ties (both exp=127):
  - mant=48'h400000_400000 -> 0x3F800000, inexact=1.
  - mant=48'h400000_C00000 -> 0x3F800002.
- Overflow: exp=254, sign=1, mant=48'hC00000_000000 -> 0xFF800000, overflow=1.
- Underflow: exp=0, mant=48'h400000_000000 -> 0x00000000 with underflow=1 (macro undefined). With the macro defined -> 0x00400000, underflow=0.
- Backpressure and specials:
  - Stimulus: stream nan, inf (sign=1), zero, then 1.0, with out_ready held low for 3 cycles after the first out_valid.
  - Outputs in order: 0x7FC00000, 0xFF800000, 0x00000000, 0x3F800000.
  - in_ready=0 while both stages are full; no loss or duplication.
  - Asserting rst mid-stream clears out_valid on the next edge.

Source files
------------

// File: rtl/fp32_mul_round_norm.sv
// fp32_mul_round_norm: FP32 multiplier back end (normalize, RNE round, pack) in a 2-stage valid/ready pipe.
// Define FPMUL_SUBNORMAL_EN to emit subnormal results instead of flushing tiny results to signed zero.
module fp32_mul_round_norm #(
  parameter int XLEN  = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sign,
  input  logic [9:0]      in_exp,
  input  logic [47:0]     in_mant,
  input  logic            in_zero,
  input  logic            in_inf,
  input  logic            in_nan,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow,
  output logic            inexact
);
  logic adv1, adv2, v1_q, v2_q;
  logic s1_q, g1_q, st1_q, z1_q, i1_q, n1_q, g1_d, st1_d;
  logic [MAN_W-1:0] f1_q, f1_d;
  logic [10:0] e1_q, e1_d;
  logic [XLEN-1:0] res_q, res_d;
  logic ovf_q, unf_q, inx_q, ovf_d, unf_d, inx_d, rup;
  logic [MAN_W:0] sum;
  logic signed [11:0] e1s, e2;
  assign adv2 = !v2_q || out_ready;
  assign adv1 = !v1_q || adv2;
  assign in_ready = adv1;
  assign f1_d  = in_mant[47] ? in_mant[46:24] : in_mant[45:23];
  assign g1_d  = in_mant[47] ? in_mant[23] : in_mant[22];
  assign st1_d = in_mant[47] ? |in_mant[22:0] : |in_mant[21:0];
  assign e1_d  = {in_exp[9], in_exp} + {10'd0, in_mant[47]};
  assign e1s = $signed({e1_q[10], e1_q});
  assign rup = g1_q && (st1_q || f1_q[0]);
  assign sum = {1'b0, f1_q} + {{MAN_W{1'b0}}, rup};
  assign e2  = e1s + $signed({11'd0, sum[MAN_W]});
`ifdef FPMUL_SUBNORMAL_EN
  // Hidden 1 plus fraction and guard, shifted right so lost bits land in the sticky field.
  logic [4:0] sh;
  logic [2*MAN_W+4:0] dn;
  logic [MAN_W:0] df, dsum;
  logic dg, dst, drup;
  assign sh   = (e1s < -12'sd24) ? 5'd26 : 5'(12'sd1 - e1s);
  assign dn   = {1'b1, f1_q, g1_q, {(MAN_W+3){1'b0}}} >> sh;
  assign df   = dn[2*MAN_W+4:MAN_W+4];
  assign dg   = dn[MAN_W+3];
  assign dst  = |dn[MAN_W+2:0] || st1_q;
  assign drup = dg && (dst || df[0]);
  assign dsum = df + {{MAN_W{1'b0}}, drup};
`endif
  always_comb begin
    res_d = {s1_q, e2[EXP_W-1:0], sum[MAN_W-1:0]};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = g1_q || st1_q;
    if (n1_q || i1_q || z1_q) begin
      res_d = n1_q ? 32'h7FC0_0000 : {s1_q, i1_q ? 31'h7F80_0000 : 31'h0};
      inx_d = 1'b0;
    end else if (e2 >= 12'sd255) begin
      res_d = {s1_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end
`ifdef FPMUL_SUBNORMAL_EN
    else if (e1s <= 0) begin
      res_d = {s1_q, {(EXP_W-1){1'b0}}, dsum};
      unf_d = dg || dst;
      inx_d = dg || dst;
    end
`else
    else if (e2 <= 0) begin
      res_d = {s1_q, {(XLEN-1){1'b0}}};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      s1_q  <= 1'b0;
      g1_q  <= 1'b0;
      st1_q <= 1'b0;
      z1_q  <= 1'b0;
      i1_q  <= 1'b0;
      n1_q  <= 1'b0;
      f1_q  <= '0;
      e1_q  <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      inx_q <= 1'b0;
    end else begin
      if (adv1) v1_q <= in_valid;
      if (adv1 && in_valid) begin
        s1_q  <= in_sign;
        g1_q  <= g1_d;
        st1_q <= st1_d;
        z1_q  <= in_zero;
        i1_q  <= in_inf;
        n1_q  <= in_nan;
        f1_q  <= f1_d;
        e1_q  <= e1_d;
      end
      if (adv2) v2_q <= v1_q;
      if (adv2 && v1_q) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
        inx_q <= inx_d;
      end
    end
  end
  assign out_valid = v2_q;
  assign result    = res_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inx_q;
endmodule

// File: tb/tb_fp32_mul_round_norm.sv
// tb_fp32_mul_round_norm: randomized scoreboard bench for the FP32 multiplier back end.
`timescale 1ns/1ps
module tb_fp32_mul_round_norm;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_sign = 1'b0, in_zero = 1'b0, in_inf = 1'b0, in_nan = 1'b0;
  logic [9:0] in_exp = '0;
  logic [47:0] in_mant = '0;
  logic in_ready, out_valid, overflow, underflow, inexact;
  logic out_ready = 1'b1;
  logic [31:0] result;
  int total = 0, bad = 0, bp_mode = 0;
  logic [34:0] sb[$];
  bit held_v = 0;
  logic [34:0] held_r;

  always #5 clk = ~clk;

  fp32_mul_round_norm dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_mant(in_mant), .in_zero(in_zero), .in_inf(in_inf), .in_nan(in_nan),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endtask

  // Reference: exact integer rounding of the product value; returns {overflow, underflow, inexact, result}.
  function automatic logic [34:0] model(input bit s, input logic [9:0] ex, input logic [47:0] m,
                                        input bit z, input bit inf, input bit nan);
    longint e, sh, q, rem, half;
    bit sub, inx;
    sub = 0;
    if (nan) return {3'b000, 32'h7FC0_0000};
    if (inf) return {3'b000, s, 31'h7F80_0000};
    if (z) return {3'b000, s, 31'h0};
    e = longint'($signed(ex)) + (m[47] ? 1 : 0);
    sh = m[47] ? 24 : 23;
`ifdef FPMUL_SUBNORMAL_EN
    if (e <= 0) begin
      sub = 1;
      sh += (1 - e > 26) ? 26 : 1 - e;
    end
`endif
    q = longint'(m) >> sh;
    rem = longint'(m) - (q << sh);
    half = longint'(1) << (sh - 1);
    inx = rem != 0;
    if (rem > half || (rem == half && q[0])) q++;
    if (sub) return {1'b0, inx, inx, s, 31'(q)};
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {3'b101, s, 31'h7F80_0000};
    if (e <= 0) return {3'b011, s, 31'h0};
    return {2'b00, inx, s, 8'(e), 23'(q)};
  endfunction

  always @(negedge clk)
    out_ready = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;

  // Monitor: pops the scoreboard on every output transfer and checks that stalled outputs hold.
  always @(negedge clk) begin
    #1;
    if (rst) held_v = 0;
    else begin
      if (held_v) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_data", {29'd0, overflow, underflow, inexact, result}, {29'd0, held_r});
      end
      held_v = out_valid && !out_ready;
      held_r = {overflow, underflow, inexact, result};
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", {63'd0, out_valid}, 64'd0);
        else chk("result", {29'd0, overflow, underflow, inexact, result}, {29'd0, sb.pop_front()});
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send(input bit s, input logic [9:0] e, input logic [47:0] m,
                      input bit z, input bit i, input bit n, input logic [34:0] want);
    int k;
    k = 0;
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; in_zero = z; in_inf = i; in_nan = n;
    #1;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!in_ready) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    else sb.push_back(want);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      #2;
      k++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    bit s, z, i, n;
    int ev, sp, k;
    logic [9:0] ex;
    logic [47:0] m;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_outputs", {29'd0, overflow, underflow, inexact, result}, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    send(0, 10'd127, 48'h400000_000000, 0, 0, 0, {3'b000, 32'h3F80_0000});
    #1;
    chk("latency_1", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    #1;
    chk("latency_2", {63'd0, out_valid}, 64'd1);
    send(0, 10'd127, 48'hC00000_000000, 0, 0, 0, {3'b000, 32'h4040_0000});
    send(0, 10'd127, 48'h7FFFFF_FFFFFF, 0, 0, 0, {3'b001, 32'h4000_0000});
    send(0, 10'd127, 48'h400000_400000, 0, 0, 0, {3'b001, 32'h3F80_0000});
    send(0, 10'd127, 48'h400000_C00000, 0, 0, 0, {3'b001, 32'h3F80_0002});
    send(1, 10'd254, 48'hC00000_000000, 0, 0, 0, {3'b101, 32'hFF80_0000});
`ifdef FPMUL_SUBNORMAL_EN
    send(0, 10'd0, 48'h400000_000000, 0, 0, 0, {3'b000, 32'h0040_0000});
`else
    send(0, 10'd0, 48'h400000_000000, 0, 0, 0, {3'b011, 32'h0000_0000});
`endif
    drain();
    bp_mode = 2;
    @(negedge clk);
    fork
      begin
        send(0, 10'd127, 48'h400000_000000, 0, 0, 1, {3'b000, 32'h7FC0_0000});
        send(1, 10'd127, 48'h400000_000000, 0, 1, 0, {3'b000, 32'hFF80_0000});
        send(0, 10'd127, 48'h400000_000000, 1, 0, 0, {3'b000, 32'h0000_0000});
        send(0, 10'd127, 48'h400000_000000, 0, 0, 0, {3'b000, 32'h3F80_0000});
      end
      begin
        k = 0;
        do begin
          @(negedge clk);
          #1;
          k++;
        end while (!out_valid && k < 30);
        chk("bp_first_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
        repeat (2) @(negedge clk);
        #1;
        bp_mode = 0;
      end
    join
    drain();
    for (int r = 0; r < 600; r++) begin
      bp_mode = (r < 300) ? 1 : 0;
      s = 1'($urandom);
      case ($urandom_range(0, 3))
        0: ev = int'($urandom_range(1, 250));
        1: ev = int'($urandom_range(245, 265));
        2: ev = int'($urandom_range(0, 60)) - 30;
        default: ev = int'($urandom_range(0, 1023)) - 512;
      endcase
      ex = 10'(ev);
      m = {16'($urandom), $urandom};
      if (m[47:46] == 2'b00) m[46] = 1'b1;
      if ($urandom_range(0, 3) == 0) m[21:0] = '0;
      if ($urandom_range(0, 5) == 0) m[22:0] = '0;
      sp = int'($urandom_range(0, 15));
      z = (sp == 1 || sp == 4);
      i = (sp == 2 || sp == 4);
      n = (sp == 3);
      send(s, ex, m, z, i, n, model(s, ex, m, z, i, n));
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end
    drain();
    #2;
    bp_mode = 2;
    @(negedge clk);
    send(0, 10'd127, 48'h400000_000000, 0, 0, 0, {3'b000, 32'h3F80_0000});
    send(0, 10'd128, 48'h400000_000000, 0, 0, 0, {3'b000, 32'h4000_0000});
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    #1;
    chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;
    bp_mode = 0;
    repeat (4) @(negedge clk);
    #1;
    chk("post_rst_idle", {63'd0, out_valid}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
